// File: rtl/serial_sub_pkg.sv
// Shared constants for the bit-serial subtractor: FSM state encoding,
// default operand width and counter sizing.
package serial_sub_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam int DEFAULT_WIDTH = 8;

  // Bit-step counter only needs to reach WIDTH-1.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell reused by the serial datapath.
module full_adder (
  input  logic Bit1,
  input  logic Bit2,
  input  logic Cin,
  output logic Y,
  output logic Cout
);

  assign Y    = Bit1 ^ Bit2 ^ Cin;
  assign Cout = (Bit1 & Bit2) | (Bit1 & Cin) | (Bit2 & Cin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B (A + ~B + 1) using a single full_adder over WIDTH cycles.
// Optional SERIAL_SUB_ADD_MODE_EN adds an 'op' input selecting A + B.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
`ifdef SERIAL_SUB_ADD_MODE_EN
  input  logic             op,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] r_sh;
  logic [CW-1:0]    count;
  logic             carry;
  logic             a_msb;
  logic             b_msb;
  logic             sum;
  logic             cout;
  logic             load_add;
  logic             add_q;

`ifdef SERIAL_SUB_ADD_MODE_EN
  assign load_add = op;
`else
  assign load_add = 1'b0;
  assign add_q    = 1'b0;
`endif

  full_adder u_fa (
    .Bit1 (a_sh[0]),
    .Bit2 (b_sh[0]),
    .Cin  (carry),
    .Y    (sum),
    .Cout (cout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      r_sh     <= '0;
      count    <= '0;
      carry    <= 1'b0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      diff     <= '0;
      borrow   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            // Subtract folds the "+1" into the initial carry.
            a_sh  <= a;
            b_sh  <= load_add ? b : ~b;
            carry <= ~load_add;
            count <= '0;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          r_sh  <= {sum, r_sh[WIDTH-1:1]};
          carry <= cout;
          count <= count + 1'b1;
          if (count == LAST) begin
            diff     <= {sum, r_sh[WIDTH-1:1]};
            borrow   <= add_q ? cout : ~cout;
            overflow <= add_q ? ((a_msb == b_msb) && (sum != a_msb))
                              : ((a_msb != b_msb) && (sum != a_msb));
            state    <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef SERIAL_SUB_ADD_MODE_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      add_q <= 1'b0;
    end else if (state == ST_IDLE && start) begin
      add_q <= op;
    end
  end
`endif

  assign busy = (state == ST_SHIFT) || (state == ST_DONE);
  assign done = (state == ST_DONE);

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial WIDTH-bit subtractor that computes A - B as A + ~B + 1 using one full_adder over WIDTH clock cycles.
- It is the sequential successor to the combinational two's-complement path: it folds the "+1" into the initial carry and reuses a single adder cell.
- It sits between operand switches/registers and the result display logic.
- It uses a start/busy/done handshake and produces borrow and signed-overflow flags.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2..16).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; captured when start is accepted.
- b  input  WIDTH  subtrahend; captured when start is accepted.
- busy  output  1  high in SHIFT and DONE.
- done  output  1  single-cycle pulse; result valid.
- diff  output  WIDTH  A - B modulo 2^WIDTH.
- borrow  output  1  1 when unsigned A < B (inverted final carry).
- overflow  output  1  signed two's-complement overflow.

Behaviour:
- Reset: state=IDLE; busy=0, done=0, diff=0, borrow=0, overflow=0; internal shift registers, counter and carry cleared.
- Reset has priority over all other inputs in every state, including mid-SHIFT; any partial result is discarded.
- States:
  - IDLE -> SHIFT on start=1.
  - SHIFT -> DONE after WIDTH bit-steps.
  - DONE -> IDLE unconditionally after one cycle.
- Accept, at edge 0, in IDLE with start=1:
  - Load a into a_sh and ~b into b_sh.
  - Set carry=1 and count=0.
  - Record sign bits a[WIDTH-1] and b[WIDTH-1].
- Each SHIFT edge:
  - Full adder takes a_sh[0], b_sh[0] and carry.
  - The sum bit shifts into r_sh at the MSB (right shift).
  - a_sh and b_sh shift right; carry takes cout; count increments.
- On the edge where count==WIDTH-1, the final bit is processed and the FSM moves to DONE. On that same edge:
  - diff is registered from the completed r_sh.
  - borrow <= ~cout.
  - overflow <= (a_msb != b_msb) && (sum_msb != a_msb).
- Latency:
  - start accepted at edge 0; done=1 in the cycle following edge WIDTH.
  - Return to IDLE at edge WIDTH+1.
  - Next start is accepted no earlier than edge WIDTH+1 (throughput 1 op per WIDTH+1 cycles).
- busy=1 from edge 0 through edge WIDTH+1 exclusive; done=1 only in DONE.
- start while busy (SHIFT or DONE) is ignored, with no queuing; a and b changing during SHIFT has no effect.
- diff, borrow and overflow hold their last values until the next result is registered. They are not cleared by a new start.
- Boundary cases:
  - b=0: carry-out is 1, so borrow=0.
  - A==B: diff=0, borrow=0.
  - Most-negative minus 1 sets overflow.

Optional Feature:
- Macro: SERIAL_SUB_ADD_MODE_EN.
- When defined:
  - Adds input op (1 bit), captured with the operands at accept.
  - op=0 subtracts (as above).
  - op=1 adds: load b instead of ~b, initial carry=0, borrow port reports the carry-out, and overflow uses sign rule (a_msb == b_msb) && (sum_msb != a_msb).
- When undefined: no op port; block is subtract-only.

Decomposition:
- Shared package serial_sub_pkg contains:
  - State encoding constants ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2.
  - DEFAULT_WIDTH=8.
  - Counter width, computed as clog2(WIDTH).
- Exactly one sub-module instance: the existing full_adder cell (Bit1, Bit2, Cin, Y, Cout), instantiated once for the serial datapath.
- FSM, counter and shift registers stay in the top module.

Test Plan:
1. Reset, then a=20, b=7, start one cycle -> done pulses 9 cycles later (WIDTH=8); diff=13, borrow=0, overflow=0; busy high 9 cycles.
2. a=5, b=9 -> diff=8'hFC, borrow=1, overflow=0.
3. a=8'h80, b=8'h01 -> diff=8'h7F, borrow=0, overflow=1. Also a=8'h7F, b=8'hFF -> diff=8'h80, overflow=1, borrow=1.
4. start held high across an operation, with a/b changed mid-SHIFT -> only the first operands are used, one done per accepted start, second start accepted at edge 9.
5. reset asserted at edge 4 of SHIFT -> next cycle busy=0, done=0, diff=0, and no done pulse ever appears for that operation; a fresh 3-2 then yields diff=1.
6. With SERIAL_SUB_ADD_MODE_EN, op=1, a=100, b=27 -> diff=127, overflow=0. Then a=100, b=28 -> diff=8'h80, overflow=1, borrow(carry)=0.
